// File: rtl/elevator_shaft_model.sv
// Plant model of one elevator car and its door: turns engine/door commands into
// floor-alignment pulses, door end-stop status and a sticky fault report.
module elevator_shaft_model #(
  parameter int unsigned FLOORS               = 8,
  parameter int unsigned TRAVEL_TICKS         = 400,
  parameter int unsigned DOOR_TICKS           = 300,
  parameter int unsigned START_FLOOR          = 0,
  parameter bit          RESET_KEEPS_POSITION = 1'b0
) (
  input  logic                      clock,
  input  logic                      a_reset,
  input  logic [1:0]                engine,
  input  logic [1:0]                door,
  output logic                      sensor_up,
  output logic                      sensor_down,
  output logic [1:0]                sensor_door,
  output logic [$clog2(FLOORS)-1:0] floor,
  output logic                      aligned,
  output logic                      fault,
  output logic [1:0]                fault_code
);

  localparam int unsigned FW = $clog2(FLOORS);
  localparam int unsigned TW = $clog2(TRAVEL_TICKS);
  localparam int unsigned DW = $clog2(DOOR_TICKS + 1);

  localparam logic [FW-1:0] TOP_FLOOR = FW'(FLOORS - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TRAVEL_TICKS - 1);
  localparam logic [DW-1:0] DOOR_FULL = DW'(DOOR_TICKS);

  localparam logic [1:0] CMD_STOP    = 2'b00;
  localparam logic [1:0] CMD_UP      = 2'b01;
  localparam logic [1:0] CMD_DOWN    = 2'b10;
  localparam logic [1:0] CMD_ILLEGAL = 2'b11;
  localparam logic [1:0] D_OPEN      = 2'b01;
  localparam logic [1:0] D_CLOSE     = 2'b10;

  localparam logic [1:0] FC_NONE       = 2'b00;
  localparam logic [1:0] FC_INTERLOCK  = 2'b01;
  localparam logic [1:0] FC_OVERTRAVEL = 2'b10;
  localparam logic [1:0] FC_ILLEGAL    = 2'b11;

  logic          run;
  logic [TW-1:0] tick;
  logic [DW-1:0] door_pos_q;

  logic [FW-1:0] floor_n;
  logic [TW-1:0] tick_n;
  logic [DW-1:0] door_pos_n;
  logic          aligned_n;
  logic          up_n;
  logic          down_n;
  logic [1:0]    sensor_door_n;
  logic          interlock_cond;
  logic          overtravel;
  logic          move_ok;
  logic [1:0]    new_code;
  logic [1:0]    code_n;

  assign interlock_cond = (door_pos_q != '0) || (door == D_OPEN);
  assign overtravel     = aligned && (((engine == CMD_UP) && (floor == TOP_FLOOR)) ||
                                      ((engine == CMD_DOWN) && (floor == '0)));
  assign move_ok        = !interlock_cond && !overtravel;

  // Highest-priority fault seen this cycle; only the first one ever is latched.
  assign new_code = ((engine == CMD_ILLEGAL) || (door == CMD_ILLEGAL)) ? FC_ILLEGAL :
                    ((engine != CMD_STOP) && interlock_cond)           ? FC_INTERLOCK :
                    overtravel                                          ? FC_OVERTRAVEL :
                                                                          FC_NONE;
  assign code_n = fault ? fault_code : new_code;

  // Car and door kinematics for the next edge.
  always_comb begin
    floor_n    = floor;
    tick_n     = tick;
    door_pos_n = door_pos_q;
    up_n       = 1'b0;
    down_n     = 1'b0;
    if (move_ok && (engine == CMD_UP)) begin
      if (tick == LAST_TICK) begin
        tick_n  = '0;
        floor_n = floor + FW'(1);
        up_n    = 1'b1;
      end else begin
        tick_n = tick + TW'(1);
      end
    end else if (move_ok && (engine == CMD_DOWN)) begin
      if (tick == '0) begin
        floor_n = floor - FW'(1);
        tick_n  = LAST_TICK;
      end else begin
        tick_n = tick - TW'(1);
        down_n = (tick == TW'(1));
      end
    end
    if ((door == D_OPEN) && aligned && (door_pos_q != DOOR_FULL)) begin
      door_pos_n = door_pos_q + DW'(1);
    end else if ((door == D_CLOSE) && (door_pos_q != '0)) begin
      door_pos_n = door_pos_q - DW'(1);
    end
  end

  assign aligned_n     = (tick_n == '0);
  assign sensor_door_n = (door_pos_n == '0)       ? 2'b10 :
                         (door_pos_n == DOOR_FULL) ? 2'b01 : 2'b00;

  // run gates updates so the first one lands on the second edge after reset falls.
  always_ff @(posedge clock or posedge a_reset) begin
    if (a_reset) begin
      run         <= 1'b0;
      door_pos_q  <= '0;
      sensor_up   <= 1'b0;
      sensor_down <= 1'b0;
      sensor_door <= 2'b10;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
    end else begin
      run <= 1'b1;
      if (run) begin
        door_pos_q  <= door_pos_n;
        sensor_up   <= up_n;
        sensor_down <= down_n;
        sensor_door <= sensor_door_n;
        fault       <= fault | (new_code != FC_NONE);
        fault_code  <= code_n;
      end
    end
  end

  generate
    if (RESET_KEEPS_POSITION) begin : g_keep_position
      // Position survives reset; it starts from START_FLOOR only at time zero.
      logic [FW-1:0] floor_q   = FW'(START_FLOOR);
      logic [TW-1:0] tick_q    = '0;
      logic          aligned_q = 1'b1;

      always_ff @(posedge clock) begin
        if (run) begin
          floor_q   <= floor_n;
          tick_q    <= tick_n;
          aligned_q <= aligned_n;
        end
      end

      assign floor   = floor_q;
      assign tick    = tick_q;
      assign aligned = aligned_q;
    end else begin : g_reset_position
      logic [FW-1:0] floor_q;
      logic [TW-1:0] tick_q;
      logic          aligned_q;

      always_ff @(posedge clock or posedge a_reset) begin
        if (a_reset) begin
          floor_q   <= FW'(START_FLOOR);
          tick_q    <= '0;
          aligned_q <= 1'b1;
        end else if (run) begin
          floor_q   <= floor_n;
          tick_q    <= tick_n;
          aligned_q <= aligned_n;
        end
      end

      assign floor   = floor_q;
      assign tick    = tick_q;
      assign aligned = aligned_q;
    end
  endgenerate

endmodule

// File: tb/tb_elevator_shaft_model.sv
// Bench for elevator_shaft_model: three configurations checked every cycle against
// a position-as-distance reference model, plus directed scenario checks.
module tb_elevator_shaft_model;

  localparam logic [1:0] UP    = 2'b01;
  localparam logic [1:0] DOWN  = 2'b10;
  localparam logic [1:0] OPEN  = 2'b01;
  localparam logic [1:0] CLOSE = 2'b10;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0][1:0] eng;
  logic [2:0][1:0] dr;
  logic [2:0]      rst;

  wire [2:0]       su, sd, al, ft;
  wire [2:0][1:0]  sdoor, fc;
  wire [2:0]       f0, f1;
  wire [1:0]       f2;

  elevator_shaft_model #(.FLOORS(8), .TRAVEL_TICKS(400), .DOOR_TICKS(300),
                         .START_FLOOR(0), .RESET_KEEPS_POSITION(1'b0)) u0 (
    .clock(clock), .a_reset(rst[0]), .engine(eng[0]), .door(dr[0]),
    .sensor_up(su[0]), .sensor_down(sd[0]), .sensor_door(sdoor[0]),
    .floor(f0), .aligned(al[0]), .fault(ft[0]), .fault_code(fc[0]));

  elevator_shaft_model #(.FLOORS(8), .TRAVEL_TICKS(400), .DOOR_TICKS(300),
                         .START_FLOOR(0), .RESET_KEEPS_POSITION(1'b1)) u1 (
    .clock(clock), .a_reset(rst[1]), .engine(eng[1]), .door(dr[1]),
    .sensor_up(su[1]), .sensor_down(sd[1]), .sensor_door(sdoor[1]),
    .floor(f1), .aligned(al[1]), .fault(ft[1]), .fault_code(fc[1]));

  elevator_shaft_model #(.FLOORS(4), .TRAVEL_TICKS(3), .DOOR_TICKS(2),
                         .START_FLOOR(1), .RESET_KEEPS_POSITION(1'b0)) u2 (
    .clock(clock), .a_reset(rst[2]), .engine(eng[2]), .door(dr[2]),
    .sensor_up(su[2]), .sensor_down(sd[2]), .sensor_door(sdoor[2]),
    .floor(f2), .aligned(al[2]), .fault(ft[2]), .fault_code(fc[2]));

  // Reference model: car position is a single distance in ticks from floor 0.
  int FL[3] = '{8, 8, 4};
  int TT[3] = '{400, 400, 3};
  int DT[3] = '{300, 300, 2};
  int SF[3] = '{0, 0, 1};
  int KP[3] = '{0, 1, 0};
  int pos[3] = '{0, 0, 3};
  int dp[3]  = '{0, 0, 0};
  int code[3] = '{0, 0, 0};
  bit run[3];
  bit mu[3];
  bit md[3];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i);
    int  fl;
    bit  al_m, ilc, ovr;
    int  nc;
    mu[i] = 1'b0;
    md[i] = 1'b0;
    if (rst[i]) begin
      run[i]  = 1'b0;
      dp[i]   = 0;
      code[i] = 0;
      if (KP[i] == 0) pos[i] = SF[i] * TT[i];
      return;
    end
    if (!run[i]) begin
      run[i] = 1'b1;
      return;
    end
    fl   = pos[i] / TT[i];
    al_m = (pos[i] % TT[i]) == 0;
    ilc  = (dp[i] != 0) || (dr[i] == OPEN);
    ovr  = al_m && (((eng[i] == UP) && (fl == FL[i] - 1)) || ((eng[i] == DOWN) && (fl == 0)));
    nc   = ((eng[i] == 2'b11) || (dr[i] == 2'b11)) ? 3 :
           ((eng[i] != 2'b00) && ilc)               ? 1 :
           ovr                                       ? 2 : 0;
    if (code[i] == 0) code[i] = nc;
    if (!ilc && !ovr && (eng[i] == UP)) begin
      pos[i]++;
      mu[i] = (pos[i] % TT[i]) == 0;
    end else if (!ilc && !ovr && (eng[i] == DOWN)) begin
      pos[i]--;
      md[i] = (pos[i] % TT[i]) == 0;
    end
    if ((dr[i] == OPEN) && al_m && (dp[i] < DT[i])) dp[i]++;
    else if ((dr[i] == CLOSE) && (dp[i] > 0)) dp[i]--;
  endtask

  task automatic check_inst(input int i);
    int obs_floor;
    int exp_door;
    obs_floor = (i == 0) ? int'(f0) : (i == 1) ? int'(f1) : int'(f2);
    exp_door  = (dp[i] == 0) ? 2 : (dp[i] == DT[i]) ? 1 : 0;
    chk($sformatf("u%0d.floor", i),       obs_floor,   pos[i] / TT[i]);
    chk($sformatf("u%0d.aligned", i),     al[i],       int'((pos[i] % TT[i]) == 0));
    chk($sformatf("u%0d.sensor_up", i),   su[i],       int'(mu[i]));
    chk($sformatf("u%0d.sensor_down", i), sd[i],       int'(md[i]));
    chk($sformatf("u%0d.sensor_door", i), sdoor[i],    exp_door);
    chk($sformatf("u%0d.fault", i),       ft[i],       int'(code[i] != 0));
    chk($sformatf("u%0d.fault_code", i),  fc[i],       code[i]);
  endtask

  // One clock: advance the model on the edge, then sample the DUTs 1 time unit later.
  task automatic cyc();
    @(posedge clock);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    for (int i = 0; i < 3; i++) check_inst(i);
  endtask

  initial begin
    int cnt;
    int hit;
    int r;
    eng = '0;
    dr  = '0;
    rst = '0;
    #1 rst = '1;
    cyc();
    cyc();
    chk("rst.floor", f0, 0);
    chk("rst.aligned", al[0], 1);
    chk("rst.sensor_door", sdoor[0], 2);
    chk("rst.fault", ft[0], 0);
    chk("rst.fault_code", fc[0], 0);
    rst = '0;
    cyc();

    // One floor up from floor 0: single pulse on the 400th update edge.
    eng[0] = UP;
    cnt = 0;
    hit = 0;
    for (int c = 1; c <= 400; c++) begin
      cyc();
      if (su[0]) begin
        cnt++;
        hit = c;
      end
    end
    eng[0] = 2'b00;
    chk("t1.pulse_count", cnt, 1);
    chk("t1.pulse_cycle", hit, 400);
    chk("t1.floor", f0, 1);
    chk("t1.aligned", al[0], 1);
    cyc();
    chk("t1.pulse_width", su[0], 0);

    // Reset mid-travel with position kept, then finish the trip downward.
    eng[1] = UP;
    repeat (200) cyc();
    eng[1] = 2'b00;
    rst[1] = 1'b1;
    cyc();
    cyc();
    rst[1] = 1'b0;
    cyc();
    chk("t2.keep_aligned", al[1], 0);
    chk("t2.keep_floor", f1, 0);
    eng[1] = DOWN;
    cnt = 0;
    repeat (200) begin
      cyc();
      cnt += int'(sd[1]);
    end
    eng[1] = 2'b00;
    chk("t2.down_pulses", cnt, 1);
    chk("t2.floor", f1, 0);
    chk("t2.aligned", al[1], 1);

    // Reset mid-travel without position keeping returns to START_FLOOR.
    eng[0] = UP;
    repeat (200) cyc();
    eng[0] = 2'b00;
    rst[0] = 1'b1;
    cyc();
    rst[0] = 1'b0;
    cyc();
    chk("t3.floor", f0, 0);
    chk("t3.aligned", al[0], 1);
    cnt = 0;
    repeat (5) begin
      cyc();
      cnt += int'(su[0]) + int'(sd[0]);
    end
    chk("t3.no_pulse", cnt, 0);

    // Door interlock at floor 2.
    eng[0] = UP;
    repeat (800) cyc();
    eng[0] = 2'b00;
    chk("t4.floor2", f0, 2);
    dr[0] = OPEN;
    repeat (299) cyc();
    chk("t4.door_mid", sdoor[0], 0);
    cyc();
    chk("t4.door_open", sdoor[0], 1);
    dr[0]  = 2'b00;
    eng[0] = UP;
    repeat (3) cyc();
    chk("t4.fault", ft[0], 1);
    chk("t4.fault_code", fc[0], 1);
    chk("t4.held_floor", f0, 2);
    chk("t4.held_aligned", al[0], 1);
    dr[0] = CLOSE;
    repeat (300) cyc();
    chk("t4.door_closed", sdoor[0], 2);
    dr[0] = 2'b00;
    cyc();
    chk("t4.resumed", al[0], 0);
    chk("t4.code_sticky", fc[0], 1);
    eng[0] = 2'b00;

    // Overtravel at the top floor, with a fresh fault register after reset.
    eng[1] = UP;
    for (int c = 0; c < 3000 && !((f1 == 3'd7) && al[1]); c++) cyc();
    eng[1] = 2'b00;
    chk("t5.reached_top", f1, 7);
    chk("t5.top_aligned", al[1], 1);
    rst[1] = 1'b1;
    cyc();
    rst[1] = 1'b0;
    cyc();
    chk("t5.code_cleared", fc[1], 0);
    eng[1] = UP;
    repeat (3) cyc();
    eng[1] = 2'b00;
    chk("t5.fault_code", fc[1], 2);
    chk("t5.no_motion", al[1], 1);
    chk("t5.floor", f1, 7);

    // Illegal engine together with door open: illegal wins.
    rst[1] = 1'b1;
    cyc();
    rst[1] = 1'b0;
    cyc();
    eng[1] = 2'b11;
    dr[1]  = OPEN;
    cyc();
    eng[1] = 2'b00;
    dr[1]  = 2'b00;
    chk("t6.priority", fc[1], 3);
    cyc();
    chk("t6.sticky", fc[1], 3);

    // Small shaft sweep: pulses equal floors crossed.
    eng[2] = UP;
    cnt = 0;
    repeat (6) begin
      cyc();
      cnt += int'(su[2]);
    end
    chk("t7.top", f2, 3);
    chk("t7.up_pulses", cnt, 3 - 1);
    eng[2] = DOWN;
    cnt = 0;
    repeat (9) begin
      cyc();
      cnt += int'(sd[2]);
    end
    eng[2] = 2'b00;
    chk("t7.bottom", f2, 0);
    chk("t7.down_pulses", cnt, 3);

    // Random commands on the small shaft, with occasional resets.
    rst[2] = 1'b1;
    cyc();
    rst[2] = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      eng[2] = (r < 45) ? UP : (r < 90) ? DOWN : (r < 99) ? 2'b00 : 2'b11;
      r = int'($urandom_range(0, 99));
      dr[2] = (r < 85) ? 2'b00 : (r < 92) ? OPEN : (r < 99) ? CLOSE : 2'b11;
      rst[2] = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst[2] = 1'b0;
    eng[2] = 2'b00;
    dr[2]  = 2'b00;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_shaft_model.md
# elevator_shaft_model

Parametrised plant model of one elevator car in its shaft and its door. It closes the loop around the elevator controller in simulation: it turns `engine` and `door` commands into floor-alignment pulses (`sensor_up`, `sensor_down`) and door end-stop status (`sensor_door`). Floor count, travel time and door time are parameters. It adds a sticky fault report and a mode that keeps the car's position through reset, so reset-mid-travel cases are reproduced faithfully.

## Interface
- FLOORS, 8, number of floors (≥2)
- TRAVEL_TICKS, 400, clock cycles to travel one floor (≥2)
- DOOR_TICKS, 300, clock cycles for a full door stroke (≥2)
- START_FLOOR, 0, initial floor (< FLOORS)
- RESET_KEEPS_POSITION, 0, 1 = car position is not affected by reset
- clock  in  1  sole clock; all state updates on its rising edge
- a_reset  in  1  asynchronous, active-high reset
- engine  in  2  01 up, 10 down, 00 stop, 11 illegal
- door  in  2  01 open, 10 close, 00 hold, 11 illegal
- sensor_up  out  1  one-cycle pulse: car aligned with a floor while moving up
- sensor_down  out  1  one-cycle pulse: car aligned with a floor while moving down
- sensor_door  out  2  10 fully closed, 01 fully open, 00 in between
- floor  out  $clog2(FLOORS)  floor at or immediately below the car
- aligned  out  1  car is exactly at a floor (tick == 0)
- fault  out  1  sticky fault flag
- fault_code  out  2  00 none, 01 interlock, 10 overtravel, 11 illegal command

## Operation
- Position state:
  - `floor` is 0..FLOORS-1.
  - `tick` is 0..TRAVEL_TICKS-1; 0 means aligned.
  - Door state: `door_pos` is 0..DOOR_TICKS; 0 = closed.
- `move_ok` requires all of the following:
  - `door_pos == 0`
  - `door != 01`
  - no overtravel: up is illegal when `floor == FLOORS-1` and `aligned`; down is illegal when `floor == 0` and `aligned`.
- Engine 01 with `move_ok`:
  - `tick` increments.
  - If `tick == TRAVEL_TICKS-1`: `tick` becomes 0, `floor` increments, and `sensor_up` is set.
- Engine 10 with `move_ok`:
  - If `tick == 0`: `floor` decrements and `tick` becomes TRAVEL_TICKS-1.
  - Else `tick` decrements; if `tick == 1`, `sensor_down` is also set.
- Engine 00 or 11: position holds.
- Door 01:
  - If `aligned` and `door_pos < DOOR_TICKS`, `door_pos` increments.
  - When not aligned, the command is ignored and raises no fault.
- Door 10: `door_pos` decrements if > 0.
- Door 00 or 11: `door_pos` holds.
- Faults are evaluated every cycle. Only the first one is latched into `fault_code`, and `fault` goes to 1.
  - Interlock (01): engine ≠ 00 while `door_pos ≠ 0` or `door == 01`.
  - Overtravel (10): engine requests motion beyond the top or bottom floor.
  - Illegal (11): engine or door equals 11.
  - Priority within one cycle: 11 > 01 > 10.
- Motion inhibition is evaluated each cycle and is not sticky. Commanded motion resumes as soon as the condition clears.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- An input sampled at edge N takes effect in the outputs after edge N.
- `sensor_up` / `sensor_down` are high for exactly one cycle: the cycle after the edge on which the car reaches alignment.
- From aligned with continuous engine 01 and door closed, `sensor_up` rises after edge TRAVEL_TICKS.
- `sensor_door` becomes 01 after DOOR_TICKS open edges from closed, and 10 after DOOR_TICKS close edges from open.
- Reset (asynchronous, held while `a_reset` = 1):
  - Cleared: `sensor_up` = 0, `sensor_down` = 0, `door_pos` = 0 (so `sensor_door` = 10), `fault` = 0, `fault_code` = 00.
  - RESET_KEEPS_POSITION = 0: `floor` = START_FLOOR, `tick` = 0, `aligned` = 1.
  - RESET_KEEPS_POSITION = 1: `floor` and `tick` are excluded from reset; they are initialised to START_FLOOR / 0 at time zero only. A reset mid-travel leaves `aligned` = 0.
- Reset deassertion is synchronised: the first update happens on the second rising edge after `a_reset` falls.
- Direction reversal mid-floor is legal and takes effect the next edge with no fault. A pulse fires only on actual arrival.

## Test plan
- Reset, then engine = 01 for 400 cycles from floor 0 → exactly one `sensor_up` pulse at cycle 400, `floor` = 1, `aligned` = 1.
- Engine 01 for 200 cycles, then reset with RESET_KEEPS_POSITION = 1 → after reset `aligned` = 0 and `floor` = 0; engine 10 for 200 cycles → one `sensor_down` pulse, `floor` = 0.
- Same sequence with RESET_KEEPS_POSITION = 0 → after reset `floor` = START_FLOOR, `tick` = 0, no pulse.
- At floor 2, door = 01 for 300 cycles → `sensor_door` = 01; then engine = 01 → `fault` = 1, `fault_code` = 01, `floor` stays 2; close the door → motion resumes, `fault_code` stays 01.
- At floor 7 (FLOORS = 8) aligned, engine = 01 → `fault_code` = 10, no motion.
- Engine = 11 and door = 01 in the same cycle → `fault_code` = 11 (priority); with FLOORS = 4, TRAVEL_TICKS = 3 up/down sweep → pulse count equals floors crossed.
